// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bring-up bus master: FSM states,
// SPART register map and the baud divisor table.
package spart_pkg;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RD,
    WAIT_TX,
    WR
  } state_e;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // Indexed by br_cfg; each entry is round(50 MHz / baud).
  localparam logic [12:0] DIVISOR [4] = '{13'h1458, 13'h0A2C, 13'h0364, 13'h01B2};

endpackage

// File: rtl/spart_driver.sv
// Stand-in for the processor in the SPART bring-up build: programs the baud
// divisor from the switches, then echoes every received byte back out.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs_n,
  output logic       iorw_n,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       tx_q_full,
  input  logic       rx_q_empty,
  output logic       cfg_done,
  output logic [7:0] echo_cnt
);

  state_e      state_q, state_d;
  logic [1:0]  br_meta_q, br_sync_q, last_br_q;
  logic [4:0]  div_hi_q;
  logic [7:0]  byte_q;
  logic        iocs_n_q, iocs_n_d;
  logic        iorw_n_q, iorw_n_d;
  logic [1:0]  ioaddr_q, ioaddr_d;
  logic [7:0]  dout_q, dout_d;
  logic        drive_q, drive_d;
  logic        cfg_done_q;
  logic [7:0]  echo_cnt_q;
  logic [12:0] div_sel;

  // Free-running through reset so the switch value is already settled when
  // the first divisor write is launched.
  always_ff @(posedge clk) begin
    br_meta_q <= br_cfg;
    br_sync_q <= br_meta_q;
  end

  // Bus registers are loaded from the next state, so each access is on the
  // bus for exactly the cycle its state is current. CFG_LO is left only once
  // its write has been launched, which covers the cycle straight out of reset.
  always_comb begin
    state_d  = state_q;
    iocs_n_d = 1'b1;
    iorw_n_d = 1'b1;
    ioaddr_d = ADDR_BUF;
    dout_d   = '0;
    drive_d  = 1'b0;
    div_sel  = DIVISOR[br_sync_q];

    case (state_q)
      CFG_LO:  state_d = iocs_n_q ? CFG_LO : CFG_HI;
      CFG_HI:  state_d = IDLE;
      IDLE: begin
        if (br_sync_q != last_br_q) state_d = CFG_LO;
        else if (!rx_q_empty)       state_d = RD;
      end
      RD:      state_d = WAIT_TX;
      WAIT_TX: if (!tx_q_full) state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = CFG_LO;
    endcase

    case (state_d)
      CFG_LO: begin
        iocs_n_d = 1'b0;
        iorw_n_d = 1'b0;
        ioaddr_d = ADDR_DBL;
        dout_d   = div_sel[7:0];
        drive_d  = 1'b1;
      end
      CFG_HI: begin
        iocs_n_d = 1'b0;
        iorw_n_d = 1'b0;
        ioaddr_d = ADDR_DBH;
        dout_d   = {3'b000, div_hi_q};
        drive_d  = 1'b1;
      end
      RD: begin
        iocs_n_d = 1'b0;
        ioaddr_d = ADDR_BUF;
      end
      WR: begin
        iocs_n_d = 1'b0;
        iorw_n_d = 1'b0;
        ioaddr_d = ADDR_BUF;
        dout_d   = byte_q;
        drive_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CFG_LO;
      iocs_n_q   <= 1'b1;
      iorw_n_q   <= 1'b1;
      ioaddr_q   <= '0;
      dout_q     <= '0;
      drive_q    <= 1'b0;
      cfg_done_q <= 1'b0;
      echo_cnt_q <= '0;
      last_br_q  <= '0;
      div_hi_q   <= '0;
      byte_q     <= '0;
    end else begin
      state_q  <= state_d;
      iocs_n_q <= iocs_n_d;
      iorw_n_q <= iorw_n_d;
      ioaddr_q <= ioaddr_d;
      dout_q   <= dout_d;
      drive_q  <= drive_d;
      // DBH reuses the setting captured with DBL so the pair never mixes.
      if (state_d == CFG_LO) begin
        last_br_q  <= br_sync_q;
        div_hi_q   <= div_sel[12:8];
        cfg_done_q <= 1'b0;
      end else if (state_q == CFG_HI) begin
        cfg_done_q <= 1'b1;
      end
      if (state_q == RD) byte_q <= databus;
      if (state_q == WR) echo_cnt_q <= echo_cnt_q + 8'd1;
    end
  end

  assign databus  = drive_q ? dout_q : 'z;
  assign iocs_n   = iocs_n_q;
  assign iorw_n   = iorw_n_q;
  assign ioaddr   = ioaddr_q;
  assign cfg_done = cfg_done_q;
  assign echo_cnt = echo_cnt_q;

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver: SPART queue model on the bus side,
// table-driven divisor checks, directed corner cases and a random echo scoreboard.
module tb_spart_driver;

  typedef struct {
    logic       rd;
    logic [1:0] addr;
    logic [7:0] data;
    logic       cd;
    int         cyc;
  } acc_t;

  typedef struct {
    logic [1:0] br;
    logic [7:0] lo;
    logic [7:0] hi;
  } vec_t;

  typedef struct {
    logic       rd;
    logic [1:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b11;
  logic       iocs_n, iorw_n;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       tx_q_full = 1'b0;
  logic       rx_q_empty = 1'b1;
  logic       cfg_done;
  logic [7:0] echo_cnt;
  logic [7:0] rd_byte = 8'h00;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rel;
  logic pop_pend = 1'b0;
  acc_t accq[$];
  logic [7:0] rxq[$];
  bit   txh[int];
  vec_t vecs[4];
  exp_t e5[6];

  always #5 clk = ~clk;

  // SPART side: drives the receive buffer only while it is being read.
  assign databus = (!iocs_n && iorw_n) ? rd_byte : 8'hzz;

  spart_driver #(.CLK_HZ(50_000_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .br_cfg    (br_cfg),
    .iocs_n    (iocs_n),
    .iorw_n    (iorw_n),
    .ioaddr    (ioaddr),
    .databus   (databus),
    .tx_q_full (tx_q_full),
    .rx_q_empty(rx_q_empty),
    .cfg_done  (cfg_done),
    .echo_cnt  (echo_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_acc(input string name, input acc_t a, input logic rd,
                         input logic [1:0] addr, input logic [7:0] data);
    chk({name, "_rw"}, a.rd, rd);
    chk({name, "_addr"}, a.addr, addr);
    chk({name, "_data"}, a.data, data);
  endtask

  function automatic void refresh();
    rx_q_empty = (rxq.size() == 0);
    rd_byte    = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endfunction

  function automatic void push(input logic [7:0] b);
    rxq.push_back(b);
    refresh();
  endfunction

  // One clock: observe the bus mid-cycle, then return just after the next edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    txh[cyc] = tx_q_full;
    if (!iocs_n) begin
      accq.push_back('{iorw_n, ioaddr, databus, cfg_done, cyc});
      if (iorw_n) pop_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    if (pop_pend) begin
      pop_pend = 1'b0;
      if (rxq.size() != 0) void'(rxq.pop_front());
    end
    refresh();
  endtask

  task automatic do_reset(input logic [1:0] br);
    rst    = 1'b1;
    br_cfg = br;
    tx_q_full = 1'b0;
    repeat (4) tick();
    chk("rst_iocs_n", iocs_n, 1);
    chk("rst_iorw_n", iorw_n, 1);
    chk("rst_ioaddr", ioaddr, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_echo_cnt", echo_cnt, 0);
    rxq.delete();
    refresh();
    accq.delete();
    rst = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (accq.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_access", accq.size() >= n, 1);
  endtask

  task automatic run_random(input int n);
    int   pushed = 0;
    int   echoed = 0;
    int   budget = 0;
    int   last = -10;
    logic [7:0] b;
    logic [7:0] expq[$];
    acc_t a;
    accq.delete();
    while (echoed < n && budget < 20000) begin
      if (pushed < n && $urandom_range(0, 2) == 0) begin
        b = 8'($urandom);
        push(b);
        expq.push_back(b);
        pushed++;
      end
      tx_q_full = ($urandom_range(0, 3) == 0);
      tick();
      budget++;
      while (accq.size() != 0) begin
        a = accq.pop_front();
        chk("rnd_gap", (a.cyc - last) >= 2, 1);
        last = a.cyc;
        chk("rnd_addr", a.addr, 0);
        if (!a.rd) begin
          chk("rnd_echo", a.data, (expq.size() != 0) ? int'(expq.pop_front()) : -1);
          chk("rnd_tx_ok", txh[a.cyc - 1], 0);
          echoed++;
        end
      end
    end
    chk("rnd_count", echoed, n);
    tx_q_full = 1'b0;
    repeat (4) tick();
    chk("rnd_extra", accq.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b00, 8'h58, 8'h14};
    vecs[1] = '{2'b01, 8'h2C, 8'h0A};
    vecs[2] = '{2'b10, 8'h64, 8'h03};
    vecs[3] = '{2'b11, 8'hB2, 8'h01};

    // Divisor programming after reset for every switch setting.
    for (int i = 0; i < 4; i++) begin
      do_reset(vecs[i].br);
      rel = cyc + 1;
      repeat (5) tick();
      chk("cfg_accesses", accq.size(), 2);
      if (accq.size() >= 2) begin
        chk_acc("cfg_dbl", accq[0], 1'b0, 2'b10, vecs[i].lo);
        chk("cfg_dbl_cyc", accq[0].cyc, rel + 1);
        chk("cfg_dbl_cd", accq[0].cd, 0);
        chk_acc("cfg_dbh", accq[1], 1'b0, 2'b11, vecs[i].hi);
        chk("cfg_dbh_cyc", accq[1].cyc, rel + 2);
        chk("cfg_dbh_cd", accq[1].cd, 0);
      end
      chk("cfg_done_after", cfg_done, 1);
      accq.delete();
    end

    // Switch change 11 -> 00 while idle.
    br_cfg = 2'b00;
    rel = cyc + 1;
    repeat (8) tick();
    chk("rep_accesses", accq.size(), 2);
    if (accq.size() >= 2) begin
      chk_acc("rep_dbl", accq[0], 1'b0, 2'b10, 8'h58);
      chk("rep_dbl_cyc", accq[0].cyc, rel + 3);
      chk("rep_dbl_cd", accq[0].cd, 0);
      chk_acc("rep_dbh", accq[1], 1'b0, 2'b11, 8'h14);
      chk("rep_dbh_cd", accq[1].cd, 0);
    end
    chk("rep_cfg_done", cfg_done, 1);
    accq.delete();

    // Single echo of 0x41.
    push(8'h41);
    rel = cyc + 1;
    repeat (8) tick();
    chk("echo_accesses", accq.size(), 2);
    if (accq.size() >= 2) begin
      chk_acc("echo_rd", accq[0], 1'b1, 2'b00, 8'h41);
      chk("echo_rd_cyc", accq[0].cyc, rel + 1);
      chk_acc("echo_wr", accq[1], 1'b0, 2'b00, 8'h41);
      chk("echo_wr_cyc", accq[1].cyc, rel + 3);
    end
    chk("echo_cnt1", echo_cnt, 1);
    accq.delete();

    // Transmit queue full for 20 cycles after the read of 0x5A.
    tx_q_full = 1'b1;
    push(8'h5A);
    wait_acc(1, 20);
    repeat (20) tick();
    chk("txfull_quiet", accq.size(), 1);
    tx_q_full = 1'b0;
    rel = cyc + 1;
    repeat (4) tick();
    chk("txfull_accesses", accq.size(), 2);
    if (accq.size() >= 2) begin
      chk_acc("txfull_rd", accq[0], 1'b1, 2'b00, 8'h5A);
      chk_acc("txfull_wr", accq[1], 1'b0, 2'b00, 8'h5A);
      chk("txfull_wr_cyc", accq[1].cyc, rel + 1);
    end
    accq.delete();

    // Switch change while a byte waits for transmit space.
    e5[0] = '{1'b1, 2'b00, 8'h77};
    e5[1] = '{1'b0, 2'b00, 8'h77};
    e5[2] = '{1'b0, 2'b10, 8'h2C};
    e5[3] = '{1'b0, 2'b11, 8'h0A};
    e5[4] = '{1'b1, 2'b00, 8'h88};
    e5[5] = '{1'b0, 2'b00, 8'h88};
    tx_q_full = 1'b1;
    push(8'h77);
    wait_acc(1, 20);
    repeat (2) tick();
    br_cfg = 2'b01;
    push(8'h88);
    repeat (6) tick();
    tx_q_full = 1'b0;
    repeat (16) tick();
    chk("pend_accesses", accq.size(), 6);
    for (int i = 0; i < 6 && i < accq.size(); i++)
      chk_acc($sformatf("pend_seq%0d", i), accq[i], e5[i].rd, e5[i].addr, e5[i].data);
    chk("pend_echo_cnt", echo_cnt, 4);
    accq.delete();

    // Reset asserted during the write phase of an echo.
    push(8'hC3);
    for (int k = 0; k < 20 && !(!iocs_n && !iorw_n && ioaddr == 2'b00); k++) tick();
    chk("wr_seen", (!iocs_n && !iorw_n && ioaddr == 2'b00), 1);
    rst = 1'b1;
    tick();
    chk("wr_abort_iocs_n", iocs_n, 1);
    chk("wr_abort_cnt", echo_cnt, 0);
    tick();
    rst = 1'b0;
    accq.delete();
    rxq.delete();
    refresh();
    rel = cyc + 1;
    repeat (5) tick();
    chk("restart_accesses", accq.size(), 2);
    if (accq.size() >= 2) begin
      chk_acc("restart_dbl", accq[0], 1'b0, 2'b10, 8'h2C);
      chk("restart_dbl_cyc", accq[0].cyc, rel + 1);
      chk_acc("restart_dbh", accq[1], 1'b0, 2'b11, 8'h0A);
    end
    accq.delete();

    // 256 random echoes against the scoreboard; counter must wrap to zero.
    run_random(200);
    chk("cnt_200", echo_cnt, 200);
    run_random(56);
    chk("cnt_wrap", echo_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
